// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the RV32M divider: operation encodings,
// divider FSM states and the fixed start-to-done latency.
package cpu_pkg;

  typedef enum logic [2:0] {
    DIV_OP_DIV  = 3'b100,
    DIV_OP_DIVU = 3'b101,
    DIV_OP_REM  = 3'b110,
    DIV_OP_REMU = 3'b111
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_ST_IDLE,
    DIV_ST_CALC,
    DIV_ST_FINISH
  } div_state_e;

  localparam int unsigned DIV_LATENCY = 34;

endpackage

// File: rtl/divider_unit.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on operand magnitudes, sign fix-up at the end.
module divider_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_start,
  input  logic [2:0]       div_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] result,
  output logic             div_busy,
  output logic             div_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q;
  logic [1:0]       op_q;
  logic             negq_q;
  logic             negr_q;
  logic             div0_q;
  logic             ovf_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] orig_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;

  logic             start_ok;
  logic             sgn_op;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   acc_sh;
  logic             ge;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] result_d;

  // Operand preparation at acceptance: magnitudes and sign flags.
  always_comb begin
    start_ok = div_start && div_op[2];
    sgn_op   = ~div_op[0];
    sa       = sgn_op & dividend[WIDTH-1];
    sb       = sgn_op & divisor[WIDTH-1];
    abs_a    = sa ? -dividend : dividend;
    abs_b    = sb ? -divisor  : divisor;
  end

  // One restoring step: shift in next dividend bit, conditionally subtract.
  always_comb begin
    acc_sh = (acc_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    ge     = acc_sh >= {1'b0, dvs_q};
    acc_d  = ge ? (acc_sh - {1'b0, dvs_q}) : acc_sh;
    quo_d  = {quo_q[WIDTH-2:0], ge};
  end

  // Final selection: divide-by-zero, then signed overflow, then normal.
  always_comb begin
    q_fix = negq_q ? -quo_q : quo_q;
    r_fix = negr_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    if (div0_q) begin
      result_d = op_q[1] ? orig_q : '1;
    end else if (ovf_q) begin
      result_d = op_q[1] ? '0 : MIN_NEG;
    end else begin
      result_d = op_q[1] ? r_fix : q_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DIV_ST_IDLE;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      orig_q   <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        DIV_ST_IDLE: begin
          done_q <= 1'b0;
          if (start_ok) begin
            op_q    <= div_op[1:0];
            negq_q  <= sa ^ sb;
            negr_q  <= sa;
            div0_q  <= (divisor == '0);
            ovf_q   <= sgn_op && (dividend == MIN_NEG) && (divisor == '1);
            dvd_q   <= abs_a;
            dvs_q   <= abs_b;
            orig_q  <= dividend;
            acc_q   <= '0;
            quo_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= DIV_ST_CALC;
          end
        end
        DIV_ST_CALC: begin
          acc_q   <= acc_d;
          quo_q   <= quo_d;
          dvd_q   <= dvd_q << 1;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_CNT) begin
            state_q <= DIV_ST_FINISH;
          end
        end
        DIV_ST_FINISH: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= DIV_ST_IDLE;
        end
        default: begin
          state_q <= DIV_ST_IDLE;
        end
      endcase
    end
  end

  assign result   = result_q;
  assign div_busy = busy_q;
  assign div_done = done_q;

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: directed RV32M corner cases plus random
// operations against a plain-arithmetic reference model.
module tb_divider_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_start = 1'b0;
  logic [2:0]  div_op = 3'b000;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] result;
  logic        div_busy;
  logic        div_done;

  divider_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_start (div_start),
    .div_op    (div_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .result    (result),
    .div_busy  (div_busy),
    .div_done  (div_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          free_cyc = 0;
  int          last_start = -1000;
  logic [31:0] held = '0;

  function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    int sa;
    int sbv;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return op[1] ? 32'd0 : 32'h8000_0000;
      sa  = $signed(a);
      sbv = $signed(b);
      return op[1] ? 32'(sa % sbv) : 32'(sa / sbv);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Called just after a falling edge; holds start for one cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string nm);
    exp_t e;
    div_start = 1'b1;
    div_op    = op;
    dividend  = a;
    divisor   = b;
    if (op[2] && cyc >= free_cyc) begin
      e.res  = ref_model(op, a, b);
      e.due  = cyc + DIV_LATENCY;
      e.name = nm;
      sb_q.push_back(e);
      free_cyc   = cyc + DIV_LATENCY;
      last_start = cyc;
    end
    @(negedge clk);
    div_start = 1'b0;
    div_op    = 3'($urandom);
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc < free_cyc && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d results outstanding, required 0", nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: busy profile, held result, and scoreboard pops on done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = '0;
    end else begin
      chk("busy", {31'd0, div_busy},
          {31'd0, (cyc > last_start) && (cyc < last_start + int'(DIV_LATENCY))});
      if (div_done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_done: got div_done=1 result %h, required no pulse (cycle %0d)",
                   result, cyc);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_result"}, result, e.res);
          chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
        end
        held = result;
      end else begin
        chk("result_hold", result, held);
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    repeat (2) @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_busy", {31'd0, div_busy}, 32'd0);
    chk("reset_done", {31'd0, div_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    wait_idle(); issue(DIV_OP_DIV,  32'd100, 32'd7, "div_100_7");
    wait_idle(); issue(DIV_OP_REM,  32'd100, 32'd7, "rem_100_7");
    wait_idle(); issue(DIV_OP_DIV,  -32'd100, 32'd7, "div_m100_7");
    wait_idle(); issue(DIV_OP_REM,  -32'd100, 32'd7, "rem_m100_7");
    wait_idle(); issue(DIV_OP_REM,  32'd100, -32'd7, "rem_100_m7");
    wait_idle(); issue(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd2, "divu_max_2");
    wait_idle(); issue(DIV_OP_REMU, 32'hFFFF_FFFF, 32'd2, "remu_max_2");
    wait_idle(); issue(DIV_OP_DIV,  32'h1234_5678, 32'd0, "div_by_zero");
    wait_idle(); issue(DIV_OP_REMU, 32'h1234_5678, 32'd0, "remu_by_zero");
    wait_idle(); issue(DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    wait_idle(); issue(DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
    drain("directed");

    issue(3'b010, 32'd40, 32'd4, "non_div_op");
    repeat (40) @(negedge clk);

    wait_idle();
    issue(DIV_OP_DIV, 32'd50, 32'd5, "busy_first");
    repeat (4) @(negedge clk);
    issue(DIV_OP_DIV, 32'd9, 32'd3, "busy_ignored");
    drain("start_while_busy");

    wait_idle();
    issue(DIV_OP_DIV, 32'd50, 32'd5, "b2b_first");
    repeat (33) @(negedge clk);
    issue(DIV_OP_DIV, 32'd9, 32'd3, "b2b_second");
    drain("start_on_done");

    wait_idle();
    issue(DIV_OP_DIV, 32'd77, 32'd7, "aborted");
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    last_start = -1000;
    free_cyc = cyc;
    #1;
    chk("abort_busy", {31'd0, div_busy}, 32'd0);
    chk("abort_done", {31'd0, div_done}, 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    wait_idle(); issue(DIV_OP_REM, 32'd77, 32'd10, "after_reset");
    drain("after_reset");

    for (int i = 0; i < 60; i++) begin
      op = {($urandom_range(0, 9) != 0), 2'($urandom)};
      a  = pick();
      b  = pick();
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(op, a, b, "random");
    end
    drain("random");
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
